// File: rtl/branch_pc_unit.sv
// branch_pc_unit: program counter, branch resolution and misaligned-target trap handling.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_inst_vld            instruction at o_pc executes this cycle
//   i_stall               hold all state this cycle
//   i_is_branch/i_is_jump instruction class (a jump wins when both are set)
//   i_funct3              branch condition select
//   i_br_less/i_br_equal  compare results from the branch comparator
//   i_target              branch / jump target
//   i_trap_ack            trap handler accepts the pending trap
//   o_br_un               unsigned-compare select for the branch comparator
//   o_pc, o_pc_four       current PC and PC + 4
//   o_taken               combinational redirect decision
//   o_trap, o_epc         trap pending flag and faulting PC
//   o_br_cnt/o_taken_cnt  saturating counters of executed / taken branches
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inst_vld,
  input  logic        i_stall,
  input  logic        i_is_branch,
  input  logic        i_is_jump,
  input  logic [2:0]  i_funct3,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  input  logic [31:0] i_target,
  input  logic        i_trap_ack,
  output logic        o_br_un,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  output logic        o_taken,
  output logic        o_trap,
  output logic [31:0] o_epc,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_taken_cnt
);

  typedef enum logic [0:0] {StRun, StTrap} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;

  logic cond;
  logic run;
  logic advance;
  logic br_exec;

  always_comb begin
    cond = 1'b0;
    case (i_funct3)
      3'b000:          cond = i_br_equal;
      3'b001:          cond = ~i_br_equal;
      3'b100, 3'b110:  cond = i_br_less;
      3'b101, 3'b111:  cond = ~i_br_less;
      default:         cond = 1'b0;
    endcase
  end

  assign run     = (state_q == StRun);
  assign o_taken = run & i_inst_vld & (i_is_jump | (i_is_branch & cond));
  assign advance = run & ~i_stall & i_inst_vld;
  // A jump with the branch flag also set is a jump only and is not counted.
  assign br_exec = advance & i_is_branch & ~i_is_jump;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    epc_d       = epc_q;
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;

    if (run) begin
      if (advance) begin
        if (o_taken) begin
          if (i_target[1:0] != 2'b00) begin
            pc_d    = TRAP_VEC;
            epc_d   = pc_q;
            state_d = StTrap;
          end else begin
            pc_d = i_target;
          end
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      // Counters saturate; a taken branch to a misaligned target still counts.
      if (br_exec && (br_cnt_q != '1)) begin
        br_cnt_d = br_cnt_q + 32'd1;
      end
      if (br_exec && cond && (taken_cnt_q != '1)) begin
        taken_cnt_d = taken_cnt_q + 32'd1;
      end
    end else begin
      pc_d = TRAP_VEC;
      if (i_trap_ack) begin
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StRun;
      pc_q        <= RESET_PC;
      epc_q       <= 32'd0;
      br_cnt_q    <= 32'd0;
      taken_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign o_br_un     = i_funct3[1];
  assign o_pc        = pc_q;
  assign o_pc_four   = pc_q + 32'd4;
  assign o_trap      = (state_q == StTrap);
  assign o_epc       = epc_q;
  assign o_br_cnt    = br_cnt_q;
  assign o_taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
module tb_branch_pc_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_inst_vld;
  logic        i_stall;
  logic        i_is_branch;
  logic        i_is_jump;
  logic [2:0]  i_funct3;
  logic        i_br_less;
  logic        i_br_equal;
  logic [31:0] i_target;
  logic        i_trap_ack;
  logic        o_br_un;
  logic [31:0] o_pc;
  logic [31:0] o_pc_four;
  logic        o_taken;
  logic        o_trap;
  logic [31:0] o_epc;
  logic [31:0] o_br_cnt;
  logic [31:0] o_taken_cnt;

  int checks = 0;
  int errors = 0;

  branch_pc_unit dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_inst_vld  (i_inst_vld),
    .i_stall     (i_stall),
    .i_is_branch (i_is_branch),
    .i_is_jump   (i_is_jump),
    .i_funct3    (i_funct3),
    .i_br_less   (i_br_less),
    .i_br_equal  (i_br_equal),
    .i_target    (i_target),
    .i_trap_ack  (i_trap_ack),
    .o_br_un     (o_br_un),
    .o_pc        (o_pc),
    .o_pc_four   (o_pc_four),
    .o_taken     (o_taken),
    .o_trap      (o_trap),
    .o_epc       (o_epc),
    .o_br_cnt    (o_br_cnt),
    .o_taken_cnt (o_taken_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_rst = 0; i_inst_vld = 0; i_stall = 0; i_is_branch = 0; i_is_jump = 0;
    i_funct3 = 3'b000; i_br_less = 0; i_br_equal = 0; i_target = 32'h0; i_trap_ack = 0;
  endtask

  task automatic state(input string tag, input logic [31:0] pc, input logic trap,
                       input logic [31:0] bc, input logic [31:0] tc);
    check({tag, "_pc"}, o_pc, pc);
    check({tag, "_trap"}, {31'd0, o_trap}, {31'd0, trap});
    check({tag, "_brcnt"}, o_br_cnt, bc);
    check({tag, "_takencnt"}, o_taken_cnt, tc);
  endtask

  initial begin
    idle();
    #1;
    // Reset
    i_rst = 1; i_stall = 1;
    tick();
    idle();
    state("reset", 32'h0, 1'b0, 32'd0, 32'd0);
    check("reset_epc", o_epc, 32'h0);
    check("reset_pc_four", o_pc_four, 32'h4);

    // Sequential fetch
    i_inst_vld = 1;
    check("seq_taken", {31'd0, o_taken}, 32'd0);
    tick(); check("seq_pc4", o_pc, 32'h4);
    tick(); check("seq_pc8", o_pc, 32'h8);
    tick(); check("seq_pc12", o_pc, 32'hC);
    check("seq_pc_four", o_pc_four, 32'h10);

    // Invalid instruction holds PC
    i_inst_vld = 0;
    tick(); check("novld_hold", o_pc, 32'hC);

    // JAL to 0x20, not counted as a branch
    i_inst_vld = 1; i_is_jump = 1; i_target = 32'h20;
    #1 check("jal_taken", {31'd0, o_taken}, 32'd1);
    tick(); idle();
    state("jal", 32'h20, 1'b0, 32'd0, 32'd0);

    // BEQ taken to 0x80
    i_inst_vld = 1; i_is_branch = 1; i_funct3 = 3'b000; i_br_equal = 1; i_target = 32'h80;
    #1 check("beq_taken", {31'd0, o_taken}, 32'd1);
    check("beq_br_un", {31'd0, o_br_un}, 32'd0);
    tick(); idle();
    state("beq", 32'h80, 1'b0, 32'd1, 32'd1);

    // BLTU not taken
    i_inst_vld = 1; i_is_branch = 1; i_funct3 = 3'b110; i_br_less = 0; i_target = 32'h200;
    #1 check("bltu_br_un", {31'd0, o_br_un}, 32'd1);
    check("bltu_taken", {31'd0, o_taken}, 32'd0);
    tick(); idle();
    state("bltu", 32'h84, 1'b0, 32'd2, 32'd1);

    // Jump to 0x40, then JALR to misaligned 0x102 traps
    i_inst_vld = 1; i_is_jump = 1; i_target = 32'h40;
    tick();
    check("jmp40_pc", o_pc, 32'h40);
    i_target = 32'h102;
    #1 check("jalr_taken", {31'd0, o_taken}, 32'd1);
    tick(); idle();
    state("trap", 32'h100, 1'b1, 32'd2, 32'd1);
    check("trap_epc", o_epc, 32'h40);

    // Trap ignores stall/vld/branch/jump for 3 cycles
    i_inst_vld = 1; i_is_jump = 1; i_is_branch = 1; i_br_equal = 1; i_target = 32'h300;
    for (int k = 0; k < 3; k++) begin
      i_stall = k[0];
      #1 check("trap_no_taken", {31'd0, o_taken}, 32'd0);
      tick();
      state("trap_hold", 32'h100, 1'b1, 32'd2, 32'd1);
    end
    idle();
    i_trap_ack = 1;
    tick(); idle();
    state("trap_ack", 32'h100, 1'b0, 32'd2, 32'd1);

    // Taken BNE under stall for 2 cycles
    i_inst_vld = 1; i_is_branch = 1; i_funct3 = 3'b001; i_br_equal = 0;
    i_target = 32'h200; i_stall = 1;
    tick(); state("stall1", 32'h100, 1'b0, 32'd2, 32'd1);
    tick(); state("stall2", 32'h100, 1'b0, 32'd2, 32'd1);
    i_stall = 0;
    tick(); idle();
    state("bne", 32'h200, 1'b0, 32'd3, 32'd2);

    // Jump and branch both high: jump only, not counted
    i_inst_vld = 1; i_is_jump = 1; i_is_branch = 1; i_funct3 = 3'b001; i_br_equal = 1;
    i_target = 32'h300;
    tick(); idle();
    state("jmp_br", 32'h300, 1'b0, 32'd3, 32'd2);

    // funct3 010 never taken, still counted
    i_inst_vld = 1; i_is_branch = 1; i_funct3 = 3'b010; i_br_equal = 1; i_br_less = 1;
    i_target = 32'h500;
    #1 check("f010_taken", {31'd0, o_taken}, 32'd0);
    tick(); idle();
    state("f010", 32'h304, 1'b0, 32'd4, 32'd2);

    // BGE (101) with less=0 taken
    i_inst_vld = 1; i_is_branch = 1; i_funct3 = 3'b101; i_br_less = 0; i_target = 32'h400;
    tick(); idle();
    state("bge", 32'h400, 1'b0, 32'd5, 32'd3);

    // BLT to misaligned target traps and is counted as taken
    i_inst_vld = 1; i_is_branch = 1; i_funct3 = 3'b100; i_br_less = 1; i_target = 32'h402;
    tick(); idle();
    state("blt_trap", 32'h100, 1'b1, 32'd6, 32'd4);
    check("blt_trap_epc", o_epc, 32'h400);

    // Reset during trap without ack
    i_rst = 1;
    tick(); idle();
    state("rst_trap", 32'h0, 1'b0, 32'd0, 32'd0);
    check("rst_trap_epc", o_epc, 32'h0);

    // PC wrap and counter saturation
    i_inst_vld = 1; i_is_jump = 1; i_target = 32'hFFFF_FFFC;
    tick(); idle();
    check("wrap_pre_pc", o_pc, 32'hFFFF_FFFC);
    check("wrap_pc_four", o_pc_four, 32'h0);
    force dut.br_cnt_q = 32'hFFFF_FFFE;
    force dut.taken_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.br_cnt_q;
    release dut.taken_cnt_q;
    i_inst_vld = 1; i_is_branch = 1; i_funct3 = 3'b000; i_br_equal = 0; i_target = 32'h10;
    tick(); idle();
    state("wrap", 32'h0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    i_inst_vld = 1; i_is_branch = 1; i_funct3 = 3'b000; i_br_equal = 1; i_target = 32'h10;
    tick();
    state("sat1", 32'h10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    i_target = 32'h20;
    tick(); idle();
    state("sat2", 32'h20, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Reset overrides stall and saturation
    i_rst = 1; i_stall = 1;
    tick(); idle();
    state("rst_sat", 32'h0, 1'b0, 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the PC loaded on reset.
REQ-002 The block SHALL have parameter TRAP_VEC, default 32'h0000_0100, which is the PC loaded on a misaligned-target trap.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_inst_vld, input, 1 bit: the instruction at o_pc executes this cycle.
REQ-006 The block SHALL have port i_stall, input, 1 bit: hold all state this cycle.
REQ-007 The block SHALL have port i_is_branch, input, 1 bit: the current instruction is a conditional branch.
REQ-008 The block SHALL have port i_is_jump, input, 1 bit: the current instruction is JAL or JALR.
REQ-009 The block SHALL have port i_funct3, input, 3 bits: the branch funct3 field.
REQ-010 The block SHALL have port i_br_less, input, 1 bit: the less-than result from brc.
REQ-011 The block SHALL have port i_br_equal, input, 1 bit: the equal result from brc.
REQ-012 The block SHALL have port i_target, input, 32 bits: the branch or jump target from the ALU.
REQ-013 The block SHALL have port i_trap_ack, input, 1 bit: the trap handler accepts the trap.
REQ-014 The block SHALL have port o_br_un, output, 1 bit: drives brc i_br_un; 1 selects an unsigned compare.
REQ-015 The block SHALL have port o_pc, output, 32 bits: the current PC (registered).
REQ-016 The block SHALL have port o_pc_four, output, 32 bits: o_pc + 4, wrapping modulo 2^32, for writeback.
REQ-017 The block SHALL have port o_taken, output, 1 bit: the redirect decision (combinational).
REQ-018 The block SHALL have port o_trap, output, 1 bit: a misaligned-target trap is pending.
REQ-019 The block SHALL have port o_epc, output, 32 bits: the PC of the faulting instruction.
REQ-020 The block SHALL have port o_br_cnt, output, 32 bits: the count of executed branches.
REQ-021 The block SHALL have port o_taken_cnt, output, 32 bits: the count of taken branches.

Function
REQ-022 o_br_un SHALL equal i_funct3[1], combinationally.
REQ-023 cond SHALL decode from i_funct3 as follows: 000 -> eq; 001 -> !eq; 100 and 110 -> less; 101 and 111 -> !less; 010 and 011 -> 0.
REQ-024 o_taken SHALL equal (state==RUN) & i_inst_vld & (i_is_jump | (i_is_branch & cond)).
REQ-025 When i_is_jump and i_is_branch are both high, the jump SHALL take priority and the instruction SHALL be treated as a jump only, not counted as a branch.
REQ-026 The FSM SHALL have two states, RUN and TRAP.
REQ-027 In RUN with i_stall=1, PC, counters and state SHALL hold; i_stall SHALL dominate all other inputs.
REQ-028 In RUN with i_stall=0 and i_inst_vld=0, PC SHALL hold.
REQ-029 In RUN with i_stall=0, i_inst_vld=1 and o_taken=0, PC SHALL become PC+4, wrapping 32'hFFFF_FFFC -> 0.
REQ-030 In RUN with o_taken=1 and i_target[1:0]==0, PC SHALL become i_target.
REQ-031 In RUN with o_taken=1 and i_target[1:0]!=0, PC SHALL become TRAP_VEC, o_epc SHALL become the old PC, and the state SHALL become TRAP.
REQ-032 In TRAP, o_trap SHALL be 1 and PC SHALL hold at TRAP_VEC.
REQ-033 In TRAP, o_taken SHALL be 0 and i_stall, i_inst_vld, i_is_branch and i_is_jump SHALL be ignored.
REQ-034 In TRAP, i_trap_ack=1 SHALL move the state to RUN on the next edge; o_trap SHALL then drop one cycle after the ack is sampled.
REQ-035 o_br_cnt SHALL increment on each RUN cycle with !i_stall & i_inst_vld & i_is_branch & !i_is_jump.
REQ-036 o_taken_cnt SHALL increment on each such cycle where cond=1, including branches that trap.
REQ-037 Both counters SHALL saturate at 32'hFFFF_FFFF and never wrap.
REQ-038 Latency: the decision SHALL be made in the same cycle, and the new o_pc SHALL be visible one cycle later.

Reset
REQ-039 With i_rst=1 at an edge: o_pc SHALL be RESET_PC, o_epc 0, state RUN, o_trap 0, o_br_cnt 0 and o_taken_cnt 0.
REQ-040 Reset SHALL override i_stall, a pending trap and counter saturation.
REQ-041 Reset asserted while in TRAP SHALL return the block to RUN at RESET_PC with no ack required.

Verification
REQ-042 Reset, then 3 cycles of i_inst_vld=1 with no branch -> o_pc sequence 0, 4, 8, 12; o_pc_four = o_pc+4.
REQ-043 At PC 0x20: BEQ (000) with eq=1 and target 0x80 -> o_taken=1, next o_pc=0x80, br_cnt=1, taken_cnt=1; then BLTU (110) with less=0 -> o_br_un=1, o_taken=0, o_pc=0x84, br_cnt=2, taken_cnt=1.
REQ-044 JALR with target 0x102 at PC 0x40 -> o_pc=0x100 (TRAP_VEC), o_trap=1, o_epc=0x40; PC held 3 cycles; i_trap_ack=1 -> RUN, o_trap=0.
REQ-045 A taken BNE with i_stall=1 for 2 cycles -> PC and counters unchanged; when the stall releases -> redirect, and counters increment exactly once.
REQ-046 Counter preloaded near saturation via 2^32-1 branches (or force) -> stays 32'hFFFF_FFFF; PC at 32'hFFFF_FFFC not taken -> 0.
REQ-047 i_rst asserted during TRAP with i_trap_ack=0 -> next cycle o_pc=RESET_PC, o_trap=0, counters 0.
